seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Iterative signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
//  Inverse of the 16x16 approximate Booth multipliers; closes multiply/divide loops in error-analysis datapaths.
//  Optional approximation truncates the final iterations, trading quotient LSBs for latency.
//  Valid/ready on both input and output sides.
// PARAMETERS
//  W           16  operand width; dividend is 2W bits
//  APPROX_LSB  0   final iterations skipped; quotient low APPROX_LSB bits forced 0 (legal 0..W-1)
// PORTS
//  clk        in   1    rising-edge clock (single clock domain)
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    operands valid
//  in_ready   out  1    block can accept operands (high only in IDLE)
//  dividend   in   2W   signed two's complement
//  divisor    in   W    signed two's complement
//  out_valid  out  1    result valid, held until out_ready
//  out_ready  in   1    consumer accepts result
//  quotient   out  W    signed, truncated toward zero
//  remainder  out  W    signed, same sign as dividend; 0 when APPROX_LSB>0
//  err        out  1    divide-by-zero or quotient overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, quotient=0, remainder=0, err=0; in_ready=1 after release.
//  Reset mid-operation aborts: no result is produced; next cycle is IDLE.
//  FSM: IDLE -> ITER -> FIX -> DONE -> IDLE; IDLE -> DONE directly on error.
//  IDLE: accept on in_valid&in_ready (edge E0). Capture |dd| (2W-bit unsigned), |dv|, sign_q=dd[2W-1]^dv[W-1], sign_r=dd[2W-1].
//    |dv|==0 -> err, quotient = sign_r ? 0x8000 : 0x7FFF, remainder = dividend[W-1:0], go DONE.
//    Overflow when |dd|[2W-1:W-1] >= |dv|, i.e. |q| >= 2^(W-1); -2^(W-1) results also flag overflow. Same saturated outputs, go DONE.
//    Otherwise: R=|dd|[2W-1:W], Q=0, shift source=|dd|[W-1:0], count=W-APPROX_LSB-1, go ITER.
//  ITER (one restoring step per cycle, W+1-bit trial subtract):
//    T={R,next dividend bit}-|dv|; T>=0 -> R=T, Q bit=1; else R={R,bit}, Q bit=0.
//    Q fills MSB-first. Leave ITER after W-APPROX_LSB steps; unfilled low Q bits stay 0.
//  FIX: quotient = sign_q ? -Q : Q; remainder = APPROX_LSB ? 0 : (sign_r ? -R : R); out_valid=1.
//  DONE: outputs stable while out_valid&~out_ready. On out_ready: out_valid=0 next edge, go IDLE.
//  Latency: normal = W-APPROX_LSB+2 edges from acceptance (W=16,A=0 -> out_valid high 18 cycles after E0, E0 cycle counted 1). Error = 1 edge.
//  Throughput: one operation in flight. in_ready=0 in ITER/FIX/DONE; no accept in the out_ready cycle.
//  in_valid is ignored outside IDLE; operands need only be stable in the acceptance cycle.
//  Zero dividend: normal path, q=0, r=0, err=0.
// STRUCTURE
//  Shared package/include (div_pkg): state encodings IDLE/ITER/FIX/DONE; helper abs/negate functions; saturation constants.
//  One sub-module: div_step (combinational W+1-bit trial subtract -> next R, q bit), instantiated once.
//  Top: FSM, operand/shift registers, step counter ($clog2(W+1) bits), sign-fix negators.
// TESTING
//  1000/7 (0x000003E8/0x0007) -> q=0x008E (142), r=0x0006, err=0; out_valid exactly at latency above.
//  -1000/7 (0xFFFFFC18/0x0007) -> q=0xFF72 (-142), r=0xFFFA (-6), err=0; also 1000/-7 -> q=0xFF72, r=0x0006.
//  0x12345678/0 -> err=1, q=0x7FFF, r=0x5678, out_valid 1 cycle after accept. 0x00010000/1 -> err=1, q=0x7FFF.
//  Backpressure: out_ready=0 for 5 cycles after out_valid -> q/r/err stable, in_ready=0. Release -> IDLE next cycle.
//  rst_n pulsed low mid-ITER -> out_valid=0, in_ready=1 immediately. A following 1000/7 completes correctly.
//  APPROX_LSB=4: 1000/7 -> q=0x0080, r=0, err=0, latency 4 cycles shorter. Random signed sweep vs golden model, A=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//  - div_state_t : FSM state encoding (IDLE/ITER/FIX/DONE)
//  - wide_t      : 64-bit scratch type used by width-generic helpers
//  - neg_w/abs_w : two's complement negate / magnitude on wide_t
//  - sat_pos/sat_neg : saturation constants for a w-bit signed result
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // Helpers work on a fixed 64-bit container; callers size-cast in and out,
    // which keeps them usable for any 2*W <= 64.
    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] wide_t;

    function automatic wide_t neg_w(input wide_t x);
        return ~x + wide_t'(1);
    endfunction

    // Magnitude of a sign-extended value; the most negative input maps to
    // its unsigned magnitude once truncated back to the original width.
    function automatic wide_t abs_w(input wide_t x);
        return x[MAXW-1] ? neg_w(x) : x;
    endfunction

    // Largest positive w-bit signed value, e.g. 0x7FFF for w=16.
    function automatic wide_t sat_pos(input int w);
        return (wide_t'(1) << (w - 1)) - wide_t'(1);
    endfunction

    // Most negative w-bit signed value, e.g. 0x8000 for w=16.
    function automatic wide_t sat_neg(input int w);
        return wide_t'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//  i_r   W  current partial remainder (always < i_dv)
//  i_bit 1  next dividend bit shifted in
//  i_dv  W  divisor magnitude
//  o_r   W  next partial remainder
//  o_q   1  quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_r,
    input  logic         i_bit,
    input  logic [W-1:0] i_dv,
    output logic [W-1:0] o_r,
    output logic         o_q
);

    logic [W:0] w_trial;
    logic [W:0] w_diff;

    // Since i_r < i_dv, the trial value is < 2*i_dv and the difference fits a
    // signed W+1-bit result, so its MSB is a valid "went negative" flag.
    assign w_trial = {i_r, i_bit};
    assign w_diff  = w_trial - {1'b0, i_dv};
    assign o_q     = ~w_diff[W];
    assign o_r     = o_q ? w_diff[W-1:0] : w_trial[W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient
// (truncated toward zero) and W-bit remainder (sign of dividend). One
// restoring step per cycle; APPROX_LSB skips the last steps and forces the
// low quotient bits (and the remainder) to zero.
// Ports:
//  clk, rst_n             clock, async active-low reset
//  in_valid / in_ready    operand handshake (ready only when idle)
//  dividend [2W], divisor [W]  signed operands
//  out_valid / out_ready  result handshake, result held until accepted
//  quotient, remainder [W] signed results
//  err                    divide-by-zero or quotient overflow (saturated q)
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W          = 16,
    parameter int APPROX_LSB = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           err
);

    localparam int CW    = $clog2(W + 1);
    localparam int STEPS = W - APPROX_LSB;

    div_state_t     r_state;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [W-1:0]   r_quot;
    logic [W-1:0]   r_remd;
    logic           r_err;
    logic [W-1:0]   r_dv_abs;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_shift;
    logic [CW-1:0]  r_cnt;
    logic           r_sign_q;
    logic           r_sign_r;

    logic [2*W-1:0] w_dd_abs;
    logic [W-1:0]   w_dv_abs;
    logic           w_dv_zero;
    logic           w_ovf;
    logic [W-1:0]   w_sat;
    logic [W-1:0]   w_step_r;
    logic           w_step_q;
    logic [W-1:0]   w_q_mag;
    logic [W-1:0]   w_q_fix;
    logic [W-1:0]   w_r_fix;

    // Operand magnitudes; the signed cast makes the 64-bit widening sign-extend.
    assign w_dd_abs  = (2*W)'(abs_w(wide_t'(signed'(dividend))));
    assign w_dv_abs  = W'(abs_w(wide_t'(signed'(divisor))));
    assign w_dv_zero = (divisor == '0);

    // |q| >= 2^(W-1) exactly when the top W+1 magnitude bits reach |dv|.
    // This also catches |dv|==0 and rejects the -2^(W-1) quotient.
    assign w_ovf = (w_dd_abs[2*W-1:W-1] >= {1'b0, w_dv_abs});
    assign w_sat = dividend[2*W-1] ? W'(sat_neg(W)) : W'(sat_pos(W));

    div_step #(.W(W)) u_step (
        .i_r   (r_rem),
        .i_bit (r_shift[W-1]),
        .i_dv  (r_dv_abs),
        .o_r   (w_step_r),
        .o_q   (w_step_q)
    );

    // r_q holds STEPS bits right-aligned; realign so skipped LSBs read as 0.
    assign w_q_mag = r_q << APPROX_LSB;
    assign w_q_fix = r_sign_q ? W'(neg_w(wide_t'(w_q_mag))) : w_q_mag;
    assign w_r_fix = (APPROX_LSB != 0) ? '0
                   : (r_sign_r ? W'(neg_w(wide_t'(r_rem))) : r_rem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_remd      <= '0;
            r_err       <= 1'b0;
            r_dv_abs    <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_sign_q   <= dividend[2*W-1] ^ divisor[W-1];
                        r_sign_r   <= dividend[2*W-1];
                        if (w_dv_zero || w_ovf) begin
                            r_quot      <= w_sat;
                            r_remd      <= dividend[W-1:0];
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_dv_abs <= w_dv_abs;
                            r_rem    <= w_dd_abs[2*W-1:W];
                            r_shift  <= w_dd_abs[W-1:0];
                            r_q      <= '0;
                            r_cnt    <= CW'(STEPS - 1);
                            r_state  <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_rem   <= w_step_r;
                    r_q     <= {r_q[W-2:0], w_step_q};
                    r_shift <= {r_shift[W-2:0], 1'b0};
                    if (r_cnt == '0) r_state <= S_FIX;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_quot      <= w_q_fix;
                    r_remd      <= w_r_fix;
                    r_err       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quot;
    assign remainder = r_remd;
    assign err       = r_err;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid4;
    logic        out_ready, out_ready4;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        in_ready, in_ready4, out_valid, out_valid4, err, err4;
    logic [15:0] quotient, quotient4, remainder, remainder4;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.W(16), .APPROX_LSB(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .err(err)
    );

    seq_restoring_divider #(.W(16), .APPROX_LSB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid4),
        .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, saturating on error, approximation
    // applied to the quotient magnitude.
    function automatic void model(input logic [31:0] a, input logic [15:0] b, input int A,
                                  output logic [15:0] q, output logic [15:0] r, output logic e);
        longint sa = longint'(signed'(a));
        longint sb = longint'(signed'(b));
        longint qq = 0;
        longint rr = 0;
        longint mag;
        if (sb != 0) begin
            qq = sa / sb;
            rr = sa % sb;
        end
        if (sb == 0 || qq > 32767 || qq < -32767) begin
            e = 1'b1;
            q = a[31] ? 16'h8000 : 16'h7FFF;
            r = a[15:0];
        end else begin
            e   = 1'b0;
            mag = (qq < 0) ? -qq : qq;
            mag = (mag >> A) << A;
            q   = 16'((qq < 0) ? -mag : mag);
            r   = (A != 0) ? 16'h0 : 16'(rr);
        end
    endfunction

    // Offer operands, wait for acceptance, then count edges (acceptance edge = 1)
    // until out_valid. Returns at the negedge where out_valid was seen.
    task automatic op(input logic [31:0] a, input logic [15:0] b, input bit u4,
                      output logic [15:0] q, output logic [15:0] r, output logic e,
                      output int lat);
        int n = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        if (u4) in_valid4 = 1'b1; else in_valid = 1'b1;
        while (!(u4 ? in_ready4 : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        lat = 1;
        while (!(u4 ? out_valid4 : out_valid) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        q = u4 ? quotient4 : quotient;
        r = u4 ? remainder4 : remainder;
        e = u4 ? err4 : err;
    endtask

    task automatic rel(input bit u4);
        if (u4) out_ready4 = 1'b1; else out_ready = 1'b1;
        @(negedge clk);
        chk("rel_valid", 32'(u4 ? out_valid4 : out_valid), 32'(0));
        chk("rel_ready", 32'(u4 ? in_ready4 : in_ready), 32'(1));
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
    endtask

    task automatic run_chk(input string tag, input logic [31:0] a, input logic [15:0] b,
                           input bit u4);
        logic [15:0] q, r, eq, er;
        logic e, ee;
        int lat;
        model(a, b, u4 ? 4 : 0, eq, er, ee);
        op(a, b, u4, q, r, e, lat);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_err"}, 32'(e), 32'(ee));
        chk({tag, "_lat"}, 32'(lat), ee ? 32'(1) : (u4 ? 32'(14) : 32'(18)));
        rel(u4);
    endtask

    logic [15:0] hq, hr;
    logic        he;
    int          hlat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
        out_ready = 1'b0; out_ready4 = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_q", 32'(quotient), 32'(0));
        chk("rst_r", 32'(remainder), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'(1));

        // Directed cases, with explicit expected values
        op(32'h000003E8, 16'h0007, 1'b0, hq, hr, he, hlat);
        chk("pos_q", 32'(hq), 32'h008E);
        chk("pos_r", 32'(hr), 32'h0006);
        chk("pos_err", 32'(he), 32'(0));
        chk("pos_lat", 32'(hlat), 32'(18));
        rel(1'b0);
        op(32'hFFFFFC18, 16'h0007, 1'b0, hq, hr, he, hlat);
        chk("negdd_q", 32'(hq), 32'hFF72);
        chk("negdd_r", 32'(hr), 32'hFFFA);
        rel(1'b0);
        op(32'h000003E8, 16'hFFF9, 1'b0, hq, hr, he, hlat);
        chk("negdv_q", 32'(hq), 32'hFF72);
        chk("negdv_r", 32'(hr), 32'h0006);
        rel(1'b0);
        op(32'h12345678, 16'h0000, 1'b0, hq, hr, he, hlat);
        chk("dz_err", 32'(he), 32'(1));
        chk("dz_q", 32'(hq), 32'h7FFF);
        chk("dz_r", 32'(hr), 32'h5678);
        chk("dz_lat", 32'(hlat), 32'(1));
        rel(1'b0);
        op(32'h00010000, 16'h0001, 1'b0, hq, hr, he, hlat);
        chk("ovf_err", 32'(he), 32'(1));
        chk("ovf_q", 32'(hq), 32'h7FFF);
        rel(1'b0);
        run_chk("minq", 32'hFFFF8000, 16'h0001, 1'b0);
        run_chk("zero_dd", 32'h00000000, 16'h0005, 1'b0);
        run_chk("neg_both", 32'hFFFFFC18, 16'hFFF9, 1'b0);

        // Backpressure: result held, in_valid ignored, no accept while DONE
        op(32'h000003E8, 16'h0007, 1'b0, hq, hr, he, hlat);
        in_valid = 1'b1;
        dividend = 32'h0000FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_ready", 32'(in_ready), 32'(0));
            chk("bp_q", 32'(quotient), 32'h008E);
            chk("bp_r", 32'(remainder), 32'h0006);
            chk("bp_err", 32'(err), 32'(0));
        end
        in_valid = 1'b0;
        rel(1'b0);

        // Reset mid-ITER aborts the operation
        dividend = 32'h000003E8; divisor = 16'h0007; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'(0));
        chk("abort_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_noresult", 32'(out_valid), 32'(0));
        run_chk("post_abort", 32'h000003E8, 16'h0007, 1'b0);

        // Approximate instance
        op(32'h000003E8, 16'h0007, 1'b1, hq, hr, he, hlat);
        chk("apx_q", 32'(hq), 32'h0080);
        chk("apx_r", 32'(hr), 32'h0000);
        chk("apx_err", 32'(he), 32'(0));
        chk("apx_lat", 32'(hlat), 32'(14));
        rel(1'b1);
        run_chk("apx_neg", 32'hFFFF1234, 16'h0123, 1'b1);

        // Random signed sweep against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [15:0] b;
            a = $urandom;
            a = 32'($signed(a) >>> $urandom_range(0, 20));
            b = 16'($urandom);
            if (i % 10 == 3) b = 16'h0000;
            run_chk("rnd", a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
